// File: rtl/memory_bus_master.sv
// rtl/memory_bus_master.sv - burst initiator for the shared single-port memory bus
module memory_bus_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 5,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [ADDR_WIDTH-1:0] reqAddress,
    input  logic [LEN_WIDTH-1:0]  reqLength,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  wrValid,
    output logic                  wrReady,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic                  rdValid,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] addressBus,
    output logic                  write,
    inout  wire  [DATA_WIDTH-1:0] dataBus
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_SAMPLE,
        S_WR_WAIT,
        S_WR_DRIVE,
        S_TURN
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] addr_bus_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  wr_ready_q;
    logic                  busy_q;
    logic                  req_ready_q;
    logic [CNT_W-1:0]      len_clamped;
    logic                  last_byte;

    // Zero-length requests still move one byte; oversize requests are cut to MAX_BURST.
    always_comb begin
        len_clamped = CNT_W'(reqLength);
        if (reqLength == '0) begin
            len_clamped = CNT_W'(1);
        end else if ({1'b0, reqLength} > (LEN_WIDTH + 1)'(MAX_BURST)) begin
            len_clamped = CNT_W'(MAX_BURST);
        end
    end

    assign last_byte = (cnt_q == CNT_W'(1));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            addr_bus_q  <= '0;
            data_out_q  <= '0;
            write_q     <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (reqValid) begin
                        addr_q      <= reqAddress;
                        cnt_q       <= len_clamped;
                        addr_bus_q  <= reqAddress;
                        write_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        req_ready_q <= 1'b0;
                        if (reqWrite) begin
                            state_q    <= S_WR_WAIT;
                            wr_ready_q <= 1'b1;
                        end else begin
                            state_q <= S_RD_WAIT;
                        end
                    end
                end
                // Address has been stable for a full cycle before the sampling edge.
                S_RD_WAIT: begin
                    state_q <= S_RD_SAMPLE;
                end
                S_RD_SAMPLE: begin
                    rd_data_q  <= dataBus;
                    rd_valid_q <= 1'b1;
                    cnt_q      <= cnt_q - CNT_W'(1);
                    addr_q     <= addr_q + ADDR_WIDTH'(1);
                    if (last_byte) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                    end else begin
                        addr_bus_q <= addr_q + ADDR_WIDTH'(1);
                        state_q    <= S_RD_WAIT;
                    end
                end
                S_WR_WAIT: begin
                    if (wrValid) begin
                        addr_bus_q <= addr_q;
                        data_out_q <= wrData;
                        write_q    <= 1'b1;
                        wr_ready_q <= 1'b0;
                        state_q    <= S_WR_DRIVE;
                    end
                end
                // Strobe stays high for exactly one full period, covering both edges.
                S_WR_DRIVE: begin
                    write_q <= 1'b0;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    addr_q  <= addr_q + ADDR_WIDTH'(1);
                    if (last_byte) begin
                        state_q <= S_TURN;
                    end else begin
                        state_q    <= S_WR_WAIT;
                        wr_ready_q <= 1'b1;
                    end
                end
                S_TURN: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    write_q     <= 1'b0;
                    wr_ready_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign dataBus    = write_q ? data_out_q : {DATA_WIDTH{1'bz}};
    assign reqReady   = req_ready_q;
    assign wrReady    = wr_ready_q;
    assign rdData     = rd_data_q;
    assign rdValid    = rd_valid_q;
    assign busy       = busy_q;
    assign addressBus = addr_bus_q;
    assign write      = write_q;

endmodule

// File: tb/tb_memory_bus_master.sv
// tb/tb_memory_bus_master.sv - bench for memory_bus_master with a behavioural memory and reference model
module tb_memory_bus_master;

    logic        clock;
    logic        resetN;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [11:0] reqAddress;
    logic [4:0]  reqLength;
    logic [7:0]  wrData;
    logic        wrValid;
    logic        wrReady;
    logic [7:0]  rdData;
    logic        rdValid;
    logic        busy;
    logic [11:0] addressBus;
    logic        write;
    wire  [7:0]  dataBus;

    memory_bus_master #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(8),
        .LEN_WIDTH (5),
        .MAX_BURST (16)
    ) dut (
        .clock     (clock),
        .resetN    (resetN),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqWrite  (reqWrite),
        .reqAddress(reqAddress),
        .reqLength (reqLength),
        .wrData    (wrData),
        .wrValid   (wrValid),
        .wrReady   (wrReady),
        .rdData    (rdData),
        .rdValid   (rdValid),
        .busy      (busy),
        .addressBus(addressBus),
        .write     (write),
        .dataBus   (dataBus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] mem     [4096];
    logic [7:0] ref_mem [4096];
    logic [7:0] wbytes  [16];
    logic       rd_en;

    // Memory drives read data while reading, an idle pattern otherwise, never while write is high.
    assign dataBus = write ? 8'hzz : (rd_en ? mem[addressBus] : 8'hA5);

    always @(posedge clock) begin
        if (write) mem[addressBus] = dataBus;
    end

    int n_tests;
    int n_fail;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Issue one burst starting at the current negedge and follow it until busy falls.
    task automatic do_req(input bit wr, input logic [11:0] addr, input logic [4:0] len,
                          input int gap, input int exp_n, input int exp_busy);
        int k, busy_cnt, nrd, nwr, rises, bidx, wait_cnt, t;
        int rr_bad, order_bad, xbad, gapbad;
        bit prev_w, wv;
        logic [11:0] a;
        k = 0; busy_cnt = 0; nrd = 0; nwr = 0; rises = 0; bidx = 0; wait_cnt = gap;
        rr_bad = 0; order_bad = 0; xbad = 0; gapbad = 0; prev_w = 1'b0; t = 0;
        rd_en      = !wr;
        reqValid   = 1'b1;
        reqWrite   = wr;
        reqAddress = addr;
        reqLength  = len;
        while (!reqReady && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) chk(1'b0, "req_ready_timeout", t, 50);
        @(posedge clock);
        #1;
        reqValid   = 1'b0;
        reqWrite   = $urandom_range(0, 1) != 0;
        reqAddress = 12'($urandom);
        reqLength  = 5'($urandom);
        do begin
            @(negedge clock);
            k++;
            if (busy) busy_cnt++;
            if (busy && reqReady) rr_bad++;
            if (rdValid) begin
                if (k != 3 + 2 * nrd) order_bad++;
                a = addr + 12'(nrd);
                chk(rdData == ref_mem[a], "rd_data", int'(rdData), int'(ref_mem[a]));
                nrd++;
            end
            if (write) begin
                nwr++;
                if (!prev_w) rises++;
            end
            prev_w = write;
            if ((write || rd_en) && $isunknown(dataBus)) xbad++;
            if (wr && wrReady && (write || dataBus !== 8'hA5)) gapbad++;
            if (wr) begin
                wv = (bidx < exp_n) && (wait_cnt >= gap);
                if (wrReady && !wv) wait_cnt++;
                wrValid = wv;
                wrData  = wv ? wbytes[bidx] : 8'($urandom);
                if (wv && wrReady) begin
                    bidx++;
                    wait_cnt = 0;
                end
            end
        end while (busy && k < 200);
        wrValid = 1'b0;
        if (k >= 200) chk(1'b0, "burst_timeout", k, 200);
        chk(busy_cnt == exp_busy, "busy_cycles", busy_cnt, exp_busy);
        chk(rr_bad == 0, "req_ready_while_busy", rr_bad, 0);
        chk(xbad == 0, "bus_unknown", xbad, 0);
        if (wr) begin
            chk(nwr == exp_n, "write_high_cycles", nwr, exp_n);
            chk(rises == exp_n, "write_pulses", rises, exp_n);
            chk(bidx == exp_n, "bytes_consumed", bidx, exp_n);
            chk(gapbad == 0, "stall_bus_released", gapbad, 0);
            for (int i = 0; i < exp_n; i++) ref_mem[addr + 12'(i)] = wbytes[i];
        end else begin
            chk(nrd == exp_n, "rd_count", nrd, exp_n);
            chk(order_bad == 0, "rd_timing", order_bad, 0);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [4:0]  len;
        int          gap;
        logic [7:0]  d0;
        int          exp_n;
        int          exp_busy;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int rc, mism, n, gap;
        bit wr;
        logic [4:0] len;
        n_tests = 0;
        n_fail  = 0;

        tbl[0] = '{1'b0, 12'h010, 5'd4,  0, 8'h00, 4,  8};
        tbl[1] = '{1'b1, 12'hFFE, 5'd3,  0, 8'h11, 3,  7};
        tbl[2] = '{1'b1, 12'h200, 5'd2,  5, 8'h5A, 2,  10};
        tbl[3] = '{1'b1, 12'h100, 5'd1,  0, 8'hC3, 1,  3};
        tbl[4] = '{1'b0, 12'h100, 5'd1,  0, 8'h00, 1,  2};
        tbl[5] = '{1'b0, 12'h020, 5'd0,  0, 8'h00, 1,  2};
        tbl[6] = '{1'b0, 12'h030, 5'd31, 0, 8'h00, 16, 32};
        tbl[7] = '{1'b1, 12'h400, 5'd0,  0, 8'h77, 1,  3};
        tbl[8] = '{1'b1, 12'h500, 5'd31, 1, 8'h01, 16, 48};
        tbl[9] = '{1'b0, 12'hFFE, 5'd4,  0, 8'h00, 4,  8};

        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem[12'h010 + i]     = 8'hA0 + 8'(i);
            ref_mem[12'h010 + i] = 8'hA0 + 8'(i);
        end

        resetN = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddress = '0; reqLength = '0;
        wrData = '0; wrValid = 1'b0; rd_en = 1'b0;
        #23;
        chk(write == 1'b0, "reset_write", int'(write), 0);
        chk(addressBus == 12'h000, "reset_address", int'(addressBus), 0);
        chk(rdValid == 1'b0, "reset_rd_valid", int'(rdValid), 0);
        chk(rdData == 8'h00, "reset_rd_data", int'(rdData), 0);
        chk(busy == 1'b0, "reset_busy", int'(busy), 0);
        chk(wrReady == 1'b0, "reset_wr_ready", int'(wrReady), 0);
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        chk(reqReady == 1'b1, "reset_req_ready", int'(reqReady), 1);

        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < 16; i++) wbytes[i] = tbl[v].d0 + 8'(17 * i);
            do_req(tbl[v].wr, tbl[v].addr, tbl[v].len, tbl[v].gap, tbl[v].exp_n, tbl[v].exp_busy);
        end
        chk(mem[12'hFFE] == 8'h11, "wrap_write_ffe", int'(mem[12'hFFE]), 8'h11);
        chk(mem[12'hFFF] == 8'h22, "wrap_write_fff", int'(mem[12'hFFF]), 8'h22);
        chk(mem[12'h000] == 8'h33, "wrap_write_000", int'(mem[12'h000]), 8'h33);
        chk(mem[12'h200] == 8'h5A && mem[12'h201] == 8'h6B, "gap_write_bytes",
            int'({mem[12'h200], mem[12'h201]}), 16'h5A6B);

        // Reset asserted during RD_WAIT of byte 2 of a 4-byte read.
        rd_en = 1'b1; reqValid = 1'b1; reqWrite = 1'b0; reqAddress = 12'h010; reqLength = 5'd4;
        @(posedge clock);
        #1;
        reqValid = 1'b0;
        repeat (3) @(negedge clock);
        chk(rdValid == 1'b1 && rdData == 8'hA0, "pre_reset_first_byte", int'(rdData), 8'hA0);
        resetN = 1'b0;
        rd_en  = 1'b0;
        #1;
        chk(busy == 1'b0 && write == 1'b0, "abort_busy_write", int'({busy, write}), 0);
        chk(rdValid == 1'b0, "abort_rd_valid", int'(rdValid), 0);
        chk(addressBus == 12'h000 && rdData == 8'h00, "abort_addr_data",
            int'({addressBus, rdData}), 0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        rc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (rdValid || busy || !reqReady) rc++;
        end
        chk(rc == 0, "post_reset_quiet", rc, 0);

        // Randomized bursts against the arithmetic reference.
        for (int r = 0; r < 30; r++) begin
            wr  = $urandom_range(0, 1) != 0;
            len = 5'($urandom);
            gap = $urandom_range(0, 2);
            n   = (len == 0) ? 1 : ((len > 16) ? 16 : int'(len));
            for (int i = 0; i < 16; i++) wbytes[i] = 8'($urandom);
            do_req(wr, 12'($urandom), len, gap, n, wr ? (2 * n + (n - 1) * gap + 1) : 2 * n);
        end

        mism = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk(mism == 0, "final_memory_image", mism, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
